// File: rtl/versatile_fifo_pkg.sv
// Shared definitions for the versatile FIFO storage array.
//   ram_state_e         : clear-sweep controller states
//   nb_lanes()          : number of byte-enable lanes for a given word/lane width
//   DEFAULT_BYTE_WIDTH  : default width of one write-enable lane
package versatile_fifo_pkg;

  localparam int DEFAULT_BYTE_WIDTH = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

  function automatic int nb_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/versatile_fifo_ram_clr_ctrl.sv
// Clear-sweep controller and write-port mux for the FIFO storage array.
// After reset, or on clr_req while running, it walks every address once and
// writes zero; during that time port A is locked out and init_busy is high.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   clr_req              : single-cycle request to re-clear (ignored while clearing)
//   we_a, be_a, adr_a,
//   d_a                  : port A write request from the pointer logic
//   init_busy            : high while the sweep runs
//   wr_be, wr_adr, wr_din: muxed write request presented to the array
//
// state | meaning
// CLEAR | sweeping zeros into ram[clr_cnt], port A and reads locked out
// RUN   | normal operation, port A writes pass through
module versatile_fifo_ram_clr_ctrl
  import versatile_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NB_LANES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  we_a,
  input  logic [NB_LANES-1:0]   be_a,
  input  logic [ADDR_WIDTH-1:0] adr_a,
  input  logic [DATA_WIDTH-1:0] d_a,
  output logic                  init_busy,
  output logic [NB_LANES-1:0]   wr_be,
  output logic [ADDR_WIDTH-1:0] wr_adr,
  output logic [DATA_WIDTH-1:0] wr_din
);

  // Last address of the sweep, compared explicitly so the counter needs no
  // extra wrap bit.
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};

  ram_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    init_busy   = 1'b0;
    wr_be       = '0;
    wr_adr      = adr_a;
    wr_din      = d_a;
    case (state)
      CLEAR: begin
        init_busy   = 1'b1;
        wr_be       = '1;
        wr_adr      = clr_cnt;
        wr_din      = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      RUN: begin
        if (we_a) begin
          wr_be = be_a;
        end
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/versatile_fifo_dual_port_ram_sc_be.sv
// Single-clock simple dual-port RAM for FIFO storage with per-byte write
// enables, a read-address register gated by re_b, and a zeroing sweep after
// reset or on clr_req.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   d_a, adr_a,
//   we_a, be_a : write port A (byte-lane enables, lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH])
//   re_b, adr_b: read port B; re_b captures adr_b
//   q_b        : read data, forced to 0 while init_busy
//   clr_req    : request a new clear sweep
//   init_busy  : high while the sweep runs
//
// Build option VERSATILE_FIFO_RAM_OUTREG_EN: adds a registered output stage
// (read latency 2 instead of 1).
module versatile_fifo_dual_port_ram_sc_be
  import versatile_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DATA_WIDTH-1:0]                        d_a,
  input  logic [ADDR_WIDTH-1:0]                        adr_a,
  input  logic                                         we_a,
  input  logic [nb_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0]  be_a,
  input  logic                                         re_b,
  input  logic [ADDR_WIDTH-1:0]                        adr_b,
  output logic [DATA_WIDTH-1:0]                        q_b,
  input  logic                                         clr_req,
  output logic                                         init_busy
);

  localparam int NB_LANES = nb_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NB_LANES-1:0]   wr_be;
  logic [ADDR_WIDTH-1:0] wr_adr;
  logic [DATA_WIDTH-1:0] wr_din;
  logic [ADDR_WIDTH-1:0] adr_b_reg;
  logic [DATA_WIDTH-1:0] rd_word;

  versatile_fifo_ram_clr_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB_LANES   (NB_LANES)
  ) u_clr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .we_a      (we_a),
    .be_a      (be_a),
    .adr_a     (adr_a),
    .d_a       (d_a),
    .init_busy (init_busy),
    .wr_be     (wr_be),
    .wr_adr    (wr_adr),
    .wr_din    (wr_din)
  );

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_LANES; i++) begin
      if (wr_be[i]) begin
        mem[wr_adr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_b_reg <= '0;
    end else if (re_b && !init_busy) begin
      adr_b_reg <= adr_b;
    end
  end

  // Reading through the registered address gives write-first behaviour and
  // lets q_b follow later writes to the held location.
  assign rd_word = mem[adr_b_reg];

`ifdef VERSATILE_FIFO_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (init_busy) begin
      q_reg <= '0;
    end else begin
      q_reg <= rd_word;
    end
  end

  assign q_b = init_busy ? '0 : q_reg;
`else
  assign q_b = init_busy ? '0 : rd_word;
`endif

endmodule
